// File: rtl/md_ctrl_pkg.sv
// md_ctrl shared types: op codes, FSM states,
// divider start levels and the operand latch bundle.
package md_ctrl_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        is_div;
    } md_opnd_t;

    function automatic logic is_md_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/md_mul_unit.sv
// 32x32 -> 64 signed/unsigned multiplier on latched
// operands; product registered when en is high.
module md_mul_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod
);

    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] full;

    assign ax   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    assign bx   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    assign full = ax * bx;

    // capture the product on the last busy cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod <= '0;
        end else if (en) begin
            prod <= full;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// EX-stage MULT/DIV sequencer: operand latch, multiply
// countdown, divider handshake, single HILO write.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES    = 2,
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ex_hold,
    input  logic        flush,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_sign,
    output logic        div_annul,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        md_stall,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    md_state_t   state;
    md_state_t   nxt;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    md_opnd_t    opnd_q;
    md_opnd_t    opnd_d;
    logic [63:0] res_q;
    logic [63:0] res_d;
    logic [63:0] prod;
    logic        mul_en;
    logic        md;

    assign md = is_md_op(op);

    md_mul_unit u_mul (
        .clk  (clk),
        .rst  (rst),
        .en   (mul_en),
        .sgn  (opnd_q.sgn),
        .a    (opnd_q.a),
        .b    (opnd_q.b),
        .prod (prod)
    );

    // state, counter, operand latch and divide result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MD_IDLE;
            cnt_q  <= '0;
            opnd_q <= '0;
            res_q  <= '0;
        end else begin
            state  <= nxt;
            cnt_q  <= cnt_d;
            opnd_q <= opnd_d;
            res_q  <= res_d;
        end
    end

    // next state and handshake outputs; flush overrides all
    always_comb begin
        nxt       = state;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        res_d     = res_q;
        mul_en    = 1'b0;
        div_start = DIV_STOP;
        div_annul = 1'b0;
        hilo_we   = 1'b0;
        unique case (state)
            MD_IDLE: begin
                if (md && !flush) begin
                    opnd_d = '{a: a, b: b,
                               sgn: is_signed_op(op),
                               is_div: is_div_op(op)};
                    if (!is_div_op(op)) begin
                        cnt_d = MUL_LOAD;
                        nxt   = MD_MUL;
                    end else if (DIV_ZERO_FAST && b == 32'd0) begin
                        res_d = {a, 32'hFFFF_FFFF};
                        nxt   = MD_DONE;
                    end else begin
                        nxt = MD_DIV;
                    end
                end
            end
            MD_MUL: begin
                if (cnt_q == 4'd0) begin
                    mul_en = 1'b1;
                    nxt    = MD_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MD_DIV: begin
                div_start = div_ready ? DIV_STOP : DIV_START;
                if (div_ready) begin
                    res_d = div_result;
                    nxt   = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!ex_hold) begin
                    hilo_we = 1'b1;
                    nxt     = MD_IDLE;
                end
            end
            default: nxt = MD_IDLE;
        endcase
        md_stall = rst && md && (state != MD_DONE);
        if (flush) begin
            nxt       = MD_IDLE;
            cnt_d     = '0;
            res_d     = res_q;
            mul_en    = 1'b0;
            hilo_we   = 1'b0;
            md_stall  = 1'b0;
            div_start = DIV_STOP;
            div_annul = (state == MD_DIV);
        end
    end

    assign div_sign = opnd_q.sgn;
    assign div_opa  = opnd_q.a;
    assign div_opb  = opnd_q.b;
    assign hi_out   = opnd_q.is_div ? res_q[63:32] : prod[63:32];
    assign lo_out   = opnd_q.is_div ? res_q[31:0]  : prod[31:0];

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized self-checking bench for md_ctrl against a
// transaction-level timeline and arithmetic reference.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    localparam int M = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ex_hold;
    logic        flush;
    logic        div_ready;
    logic [63:0] div_result;
    logic        div_start;
    logic        div_sign;
    logic        div_annul;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        md_stall;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_tests = 0;
    int n_fail  = 0;

    md_ctrl #(.MUL_CYCLES(M), .DIV_ZERO_FAST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .a          (a),
        .b          (b),
        .ex_hold    (ex_hold),
        .flush      (flush),
        .div_ready  (div_ready),
        .div_result (div_result),
        .div_start  (div_start),
        .div_sign   (div_sign),
        .div_annul  (div_annul),
        .div_opa    (div_opa),
        .div_opb    (div_opb),
        .md_stall   (md_stall),
        .hilo_we    (hilo_we),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [7:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        int              q;
        int              r;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        if (o == EXE_MULT_OP) return 64'(sx * sy);
        if (o == EXE_MULTU_OP) return 64'(ux * uy);
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == EXE_DIV_OP) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {32'(r), 32'(q)};
        end
        return {x % y, x / y};
    endfunction

    function automatic logic [7:0] non_md_op();
        logic [7:0] o;
        o = 8'($urandom);
        if (is_md_op(o)) o = o ^ 8'h40;
        return o;
    endfunction

    task automatic run_op(input string nm, input logic [7:0] o,
                          input logic [31:0] ai, input logic [31:0] bi,
                          input int hold, input int flush_at,
                          input int lat);
        bit          mul;
        bit          slow;
        bit          fl;
        int          done_c;
        int          we_c;
        int          last;
        logic [63:0] expv;
        mul    = (o == EXE_MULT_OP) || (o == EXE_MULTU_OP);
        slow   = !mul && (bi != 32'd0);
        done_c = mul ? M + 1 : (slow ? 2 + lat : 1);
        we_c   = done_c + hold;
        last   = (flush_at >= 0 && flush_at <= we_c) ? flush_at : we_c;
        expv   = ref_result(o, ai, bi);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            fl         = (c == flush_at);
            op         = o;
            a          = (c == 0) ? ai : 32'($urandom);
            b          = (c == 0) ? bi : 32'($urandom);
            flush      = fl;
            ex_hold    = (c >= done_c) ? (c < we_c) : 1'($urandom_range(0, 1));
            div_ready  = slow && (c == 1 + lat);
            div_result = div_ready ? expv : {32'($urandom), 32'($urandom)};
            #1;
            chk({nm, ":stall"}, md_stall, !fl && c < done_c);
            chk({nm, ":we"}, hilo_we, !fl && c == we_c);
            chk({nm, ":start"}, div_start,
                slow && !fl && c >= 1 && c <= lat);
            chk({nm, ":annul"}, div_annul,
                slow && fl && c >= 1 && c <= 1 + lat);
            if (slow && !fl && c == 1) begin
                chk({nm, ":opa"}, div_opa, ai);
                chk({nm, ":opb"}, div_opb, bi);
                chk({nm, ":sign"}, div_sign, o == EXE_DIV_OP);
            end
            if (!fl && c == we_c) begin
                chk({nm, ":hi"}, hi_out, expv[63:32]);
                chk({nm, ":lo"}, lo_out, expv[31:0]);
            end
        end
        @(negedge clk);
        op        = non_md_op();
        a         = 32'($urandom);
        b         = 32'($urandom);
        flush     = 1'b0;
        ex_hold   = 1'b0;
        div_ready = 1'b0;
        #1;
        chk({nm, ":idle_stall"}, md_stall, 1'b0);
        chk({nm, ":idle_we"}, hilo_we, 1'b0);
        chk({nm, ":idle_start"}, div_start, 1'b0);
        if (last == we_c) chk({nm, ":idle_hold"}, {hi_out, lo_out}, expv);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ":stall"}, md_stall, 1'b0);
        chk({nm, ":we"}, hilo_we, 1'b0);
        chk({nm, ":start"}, div_start, 1'b0);
        chk({nm, ":annul"}, div_annul, 1'b0);
        chk({nm, ":sign"}, div_sign, 1'b0);
        chk({nm, ":opab"}, {div_opa, div_opb}, 64'd0);
        chk({nm, ":hilo"}, {hi_out, lo_out}, 64'd0);
    endtask

    initial begin
        logic [7:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          fa;
        rst        = 1'b0;
        op         = 8'd0;
        a          = '0;
        b          = '0;
        ex_hold    = 1'b0;
        flush      = 1'b0;
        div_ready  = 1'b0;
        div_result = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        run_op("mult_neg", EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, 0, -1, 0);
        run_op("divu_33", EXE_DIVU_OP, 32'd100, 32'd7, 0, -1, 33);
        run_op("div_zero", EXE_DIV_OP, 32'd5, 32'd0, 0, -1, 0);
        run_op("div_flush", EXE_DIV_OP, 32'd1234, 32'd17, 0, 10, 33);
        run_op("multu_hold", EXE_MULTU_OP, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 4, -1, 0);
        run_op("flush_idle", EXE_MULT_OP, 32'd7, 32'd9, 0, 0, 0);
        run_op("flush_rdy", EXE_DIVU_OP, 32'd50, 32'd3, 0, 4, 3);
        run_op("flush_done", EXE_MULTU_OP, 32'd6, 32'd7, 2, M + 2, 0);
        run_op("sdiv_neg", EXE_DIV_OP, 32'hFFFF_FF9C, 32'd7, 1, -1, 5);

        @(negedge clk);
        op = EXE_MULT_OP;
        a  = 32'd11;
        b  = 32'd13;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        op  = 8'd0;
        rst = 1'b1;
        run_op("after_rst", EXE_MULT_OP, 32'd11, 32'd13, 0, -1, 0);

        for (int i = 0; i < 60; i++) begin
            ro = EXE_MULT_OP + 8'($urandom_range(0, 3));
            ra = 32'($urandom);
            rb = 32'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (ro == EXE_DIV_OP && ra == 32'h8000_0000 &&
                rb == 32'hFFFF_FFFF) rb = 32'd1;
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_op("rand", ro, ra, rb, int'($urandom_range(0, 3)), fa,
                   int'($urandom_range(1, 12)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequencing controller for the multi-cycle MULT/MULTU/DIV/DIVU path in the EX stage. It sits beside the ALU and owns the operand latch, the multiply pipeline countdown and the start/annul handshake of the iterative divider (div).
- It raises the pipeline stall while an operation is in flight, holds the 64-bit result across downstream holds, and issues exactly one HILO write per completed, un-flushed instruction.

Parameters:
- MUL_CYCLES, 2, number of busy cycles for a multiply after acceptance (1..15).
- DIV_ZERO_FAST, 1, 1 = divide-by-zero bypasses the divider and completes in the next cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- op  in  8  EX-stage ALU op code (`EXE_*_OP encodings from defines.vh)
- a  in  32  rs operand
- b  in  32  rt operand
- ex_hold  in  1  downstream stall; EX instruction does not advance this cycle
- flush  in  1  exception/flush; kill the in-flight EX instruction
- div_ready  in  1  divider result valid (from div)
- div_result  in  64  divider output; [63:32] = remainder, [31:0] = quotient
- div_start  out  1  level request to divider; held until div_ready
- div_sign  out  1  1 = signed divide
- div_annul  out  1  one-cycle cancel pulse to divider
- div_opa  out  32  latched dividend
- div_opb  out  32  latched divisor
- md_stall  out  1  stall request to the pipeline controller
- hilo_we  out  1  one-cycle HILO write enable
- hi_out  out  32  result for HI
- lo_out  out  32  result for LO

Behaviour:
- md op = op in {MULT, MULTU, DIV, DIVU}. Any other op is ignored: state stays IDLE, md_stall = 0.
- States:
  - IDLE, MUL_BUSY, DIV_BUSY, DONE.
- Reset values:
  - state = IDLE, counter = 0, all registered outputs = 0.
  - div_start, div_annul, hilo_we, md_stall = 0.
- IDLE, on an md op with no flush:
  - latch a, b, signedness and kind.
  - MULT/MULTU: load counter = MUL_CYCLES-1 and go to MUL_BUSY.
  - DIV/DIVU with b == 0 and DIV_ZERO_FAST = 1: result = {a, 32'hFFFF_FFFF}; go to DONE.
  - DIV/DIVU otherwise: go to DIV_BUSY.
- MUL_BUSY:
  - decrement the counter.
  - at counter == 0, register the product (signed or unsigned 64-bit per the latched kind) and go to DONE.
  - Total stall = MUL_CYCLES+1 cycles; DONE is in cycle MUL_CYCLES+1 after acceptance.
- DIV_BUSY:
  - div_start = 1; div_sign = latched sign; div_opa/div_opb = latched operands.
  - on div_ready = 1, capture div_result and go to DONE. div_start drops in the same cycle (combinational on div_ready).
- DONE:
  - md_stall = 0; hi_out/lo_out are valid and held.
  - if ex_hold = 1: stay in DONE, hilo_we = 0, result unchanged.
  - if ex_hold = 0: hilo_we = 1 this cycle, then go to IDLE.
- md_stall:
  - 1 whenever an md op is present and state != DONE, including the IDLE acceptance cycle.
  - forced to 0 in any cycle with flush = 1.
- flush, in any state: next state = IDLE and hilo_we = 0 in that cycle.
  - If state is DIV_BUSY, div_annul = 1 for exactly that cycle and div_start = 0.
  - flush in DONE suppresses the write.
  - flush in IDLE with an md op: the op is not accepted.
- flush and div_ready in the same cycle: flush wins; result discarded.
- Operand changes on a/b after acceptance have no effect; only latched values are used.
- hi_out/lo_out keep their last value in IDLE; they are only meaningful while hilo_we = 1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The divider shares rst and needs no annul.
- MUL_CYCLES = 1: MUL_BUSY lasts one cycle (counter loaded with 0).

Decomposition:
- Use the existing defines.vh; add the state encoding macros MD_IDLE/MD_MUL/MD_DIV/MD_DONE there.
- Reuse `DivStart/`DivStop for the div_start levels.
- One natural sub-module: md_mul_unit, the latched-operand 64-bit signed/unsigned multiplier with registered output.
- The divider stays external (div); md_ctrl only drives its handshake.

Test Plan:
- MULT a=0xFFFF_FFFE (-2), b=3, MUL_CYCLES=2 -> md_stall high 3 cycles, then hilo_we for 1 cycle with hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- DIVU a=100, b=7; model asserts div_ready after 33 cycles with {2, 14} -> div_start high until ready, then hilo_we with hi=2, lo=14 exactly once.
- DIV a=5, b=0 -> no div_start; next cycle DONE with hi=5, lo=0xFFFF_FFFF, stall 1 cycle.
- DIV in flight, flush at cycle 10 -> div_annul pulse for 1 cycle, div_start=0, state IDLE, no hilo_we.
- MULTU 0xFFFF_FFFF*0xFFFF_FFFF with ex_hold high 4 cycles in DONE -> hi=0xFFFF_FFFE, lo=1 held, single hilo_we on the first cycle with ex_hold=0.
- rst low during MUL_BUSY -> all outputs 0 immediately; after release a new MULT completes normally.
